// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between four producers, the shared 4:1 mux and one sink.
// The arbiter takes the slave side; the surrounding fabric the master side.
interface mux4_rr_arbiter_if #(
   parameter int W = 8
);
   logic [3:0]     req;
   logic [4*W-1:0] data_in;
   logic           ready;
   logic [3:0]     gnt;
   logic [1:0]     select;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           busy;
   logic           beat;

   modport master (
      output req, data_in, ready,
      input  gnt, select, out_data,
      input  out_valid, busy, beat
   );

   modport slave (
      input  req, data_in, ready,
      output gnt, select, out_data,
      output out_valid, busy, beat
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a 4:1 data mux with per-tenure burst limit.
// One dead IDLE cycle separates tenures; arbitration happens there.
module mux4_rr_arbiter #(
   parameter int W = 8,
   parameter int MAX_BURST = 4
) (
   input logic              clk,
   input logic              rst_n,
   mux4_rr_arbiter_if.slave bus
);
   localparam int CW =
      (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [CW-1:0] LASTC =
      (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic [1:0]    last;
   logic          busy;
   logic [CW-1:0] count;

   logic [7:0]    req2;
   logic [2:0]    ptr;
   logic [3:0]    rot;
   logic [1:0]    off;
   logic [1:0]    nxt_idx;
   logic [W-1:0]  dmux;
   logic          ov;
   logic          xfer;
   logic          done;

   // rot[k] is requester (last+1+k) mod 4
   assign req2 = {bus.req, bus.req};
   assign ptr  = {1'b0, last} + 3'd1;
   assign rot  = req2[ptr +: 4];

   always_comb begin
      off = 2'd3;
      priority case (1'b1)
         rot[0]:  off = 2'd0;
         rot[1]:  off = 2'd1;
         rot[2]:  off = 2'd2;
         default: off = 2'd3;
      endcase
   end

   assign nxt_idx = last + 2'd1 + off;

   always_comb begin
      dmux = bus.data_in[W-1:0];
      unique case (sel)
         2'd0: dmux = bus.data_in[0*W +: W];
         2'd1: dmux = bus.data_in[1*W +: W];
         2'd2: dmux = bus.data_in[2*W +: W];
         2'd3: dmux = bus.data_in[3*W +: W];
         default: dmux = bus.data_in[W-1:0];
      endcase
   end

   assign ov   = busy & bus.req[sel];
   assign xfer = ov & bus.ready;
   assign done = (MAX_BURST != 0) && xfer
                 && (count == LASTC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         busy  <= 1'b0;
         count <= '0;
         last  <= 2'd3;
      end else begin
         unique case (state)
            IDLE: begin
               if (|bus.req) begin
                  state <= GRANT;
                  sel   <= nxt_idx;
                  gnt   <= 4'b0001 << nxt_idx;
                  busy  <= 1'b1;
                  count <= '0;
               end
            end
            GRANT: begin
               if (!bus.req[sel] || done) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  busy  <= 1'b0;
                  last  <= sel;
                  count <= '0;
               end else if (xfer) begin
                  count <= count + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt;
   assign bus.select    = sel;
   assign bus.busy      = busy;
   assign bus.out_data  = dmux;
   assign bus.out_valid = ov;
   assign bus.beat      = xfer;
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 data multiplexer among four requesters feeding a single downstream consumer. It owns the 2-bit mux select, issues one-hot grants, and bounds each tenure with a burst limit. The output path is the 4:1 mux, combinational from the granted input under a registered select. The block sits between four producer ports and one valid/ready sink.

Parameters:
W, 8, data width per requester
MAX_BURST, 4, max accepted beats per grant tenure; 0 = unlimited (hold until req drops)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  per-requester request, level; req[i] must stay high while requester i has data
data_in  input  4*W  requester data, slice i = data_in[i*W +: W]
ready  input  1  downstream accepts out_data this cycle
gnt  output  4  one-hot grant, registered; 0 when idle
select  output  2  registered mux select = granted index
out_data  output  W  data_in slice chosen by select (combinational 4:1 mux)
out_valid  output  1  busy & req[select], combinational
busy  output  1  registered; 1 in GRANT state
beat  output  1  out_valid & ready (transfer strobe)

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, gnt=0, select=0, busy=0, beat count=0, rr pointer last=3 (requester 0 has first priority). out_valid=0 and beat=0 follow from busy=0. out_data = data_in[0 slice] (select=0).
- Reset dominates every other event, including mid-burst; no beat is counted in the reset cycle.
- States: IDLE, GRANT.
- IDLE: if req!=0, choose first set bit scanning last+1, last+2, last+3, last (mod 4). Next edge: state=GRANT, select=idx, gnt=1<<idx, busy=1, count=0. If req==0, stay IDLE, all outputs hold reset values except select, which keeps its last value.
- Grant latency: req high in cycle N (IDLE) -> gnt/select valid in cycle N+1. out_valid can assert in N+1.
- GRANT: transfer when out_valid & ready; count increments per transfer (width clog2(MAX_BURST+1), min 1).
- Release from GRANT to IDLE at the next edge when either condition holds: (a) req[select]==0; (b) MAX_BURST!=0 and a transfer occurs with count==MAX_BURST-1. On release: gnt=0, busy=0, last=select, count=0. select keeps its value.
- Release always passes through one IDLE cycle (dead cycle) before the next grant. Arbitration happens in that IDLE cycle.
- Non-granted req changes never affect the current tenure. Arbitration uses the req sampled in the IDLE cycle only.
- ready with out_valid=0 has no effect. Downstream may hold ready low indefinitely, and the grant is held while req stays high.
- Requester dropping req in the same cycle ready is high: no transfer (out_valid=0); release per (a).
- Only one requester active: it is re-granted after each dead cycle.
- gnt is always one-hot or zero, and gnt!=0 iff busy.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, select=0, out_valid=0. rst_n=1 -> next cycle gnt=4'b0001, select=0.
- Round robin: req=4'b1111, ready=1, MAX_BURST=4, data slice i = 8'hA0+i -> 4 beats each of A0, A1, A2, A3, then A0. There is one dead cycle between tenures, and gnt sequence is 0001, 0010, 0100, 1000, 0001.
- Pointer skip: last=0, req=4'b1001 in IDLE -> grant 3 (gnt=1000, select=3). After release with req=1001, next grant is 0.
- Backpressure: granted requester 1, ready=0 for 5 cycles -> out_valid=1, beat=0, count stays 0, grant held. ready=1 -> exactly 4 beats, then release.
- Early release: requester 2 granted, 2 beats, then req[2]=0 -> out_valid=0 in that cycle, gnt=0 next cycle, last=2. With req=4'b1111, next grant is 3.
- Reset mid-burst: after 2 of 4 beats, rst_n=0 one cycle -> gnt=0, busy=0, last=3. After release with req=4'b0110, grant 1 first.
- MAX_BURST=0 variant: single requester 0 streaming 20 beats with ready=1 -> a single tenure of 20 beats with no dead cycles, released only when req[0] drops.
